// File: rtl/divider_seq_nbit.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_FASTPATH_EN: zero divisor finishes in one edge.
module divider_seq_nbit #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_BITS-1:0] dividend,
    input  logic [NUM_BITS-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] quotient,
    output logic [NUM_BITS-1:0] remainder,
    output logic                div_by_zero
);

    localparam int N  = NUM_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  r_q, r_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;

    logic [N:0]    rp;
    logic          ge;
    logic [N-1:0]  diff;
    logic [N-1:0]  r_step;
    logic [N-1:0]  q_step;

    // Partial remainder stays below the divisor, so an N-bit difference suffices.
    assign rp     = {r_q, q_q[N-1]};
    assign ge     = (rp >= {1'b0, dvs_q});
    assign diff   = rp[N-1:0] - dvs_q;
    assign r_step = ge ? diff : rp[N-1:0];
    assign q_step = {q_q[N-2:0], ge};

`ifdef DIV_ZERO_FASTPATH_EN
    logic dz_q, dz_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
`ifdef DIV_ZERO_FASTPATH_EN
        dz_d    = dz_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    r_d     = '0;
                    q_d     = dividend;
                    dvs_d   = divisor;
`ifdef DIV_ZERO_FASTPATH_EN
                    dz_d    = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    quo_d   = q_step;
                    rem_d   = r_step;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

`ifdef DIV_ZERO_FASTPATH_EN
    always_ff @(posedge clk) begin
        if (reset) dz_q <= 1'b0;
        else       dz_q <= dz_d;
    end
    assign div_by_zero = dz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign busy      = (state_q == CALC);
    assign done      = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_divider_seq_nbit.sv
// Directed-vector bench for divider_seq_nbit (NUM_BITS = 8).
module tb_divider_seq_nbit;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    divider_seq_nbit #(.NUM_BITS(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] eq;
        logic [N-1:0] er;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Caller has start/operands set just before an edge; counts edges to done.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (busy) bcnt++;
            if (done) return;
        end
        lat = -1;
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output int lat, output int bcnt);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        wait_done(lat, bcnt);
    endtask

    function automatic int exp_lat(input logic [N-1:0] b);
`ifdef DIV_ZERO_FASTPATH_EN
        return (b == 0) ? 1 : N + 1;
`else
        return N + 1;
`endif
    endfunction

    function automatic int exp_dz(input logic [N-1:0] b);
`ifdef DIV_ZERO_FASTPATH_EN
        return (b == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    initial begin
        vec_t vecs[8];
        int   lat;
        int   bcnt;
        bit   seen;

        vecs[0] = '{a: 8'd200, b: 8'd7,   eq: 8'd28,  er: 8'd4};
        vecs[1] = '{a: 8'd255, b: 8'd1,   eq: 8'd255, er: 8'd0};
        vecs[2] = '{a: 8'd5,   b: 8'd9,   eq: 8'd0,   er: 8'd5};
        vecs[3] = '{a: 8'd100, b: 8'd0,   eq: 8'd255, er: 8'd100};
        vecs[4] = '{a: 8'd81,  b: 8'd9,   eq: 8'd9,   er: 8'd0};
        vecs[5] = '{a: 8'd0,   b: 8'd5,   eq: 8'd0,   er: 8'd0};
        vecs[6] = '{a: 8'd255, b: 8'd255, eq: 8'd1,   er: 8'd0};
        vecs[7] = '{a: 8'd255, b: 8'd16,  eq: 8'd15,  er: 8'd15};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst quo", int'(quotient), 0);
        chk("rst rem", int'(remainder), 0);
        chk("rst dz", int'(div_by_zero), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, bcnt);
            chk($sformatf("v%0d lat", i), lat, exp_lat(vecs[i].b));
            chk($sformatf("v%0d busy", i), bcnt,
                exp_lat(vecs[i].b) - 1);
            chk($sformatf("v%0d quo", i), int'(quotient), int'(vecs[i].eq));
            chk($sformatf("v%0d rem", i), int'(remainder), int'(vecs[i].er));
            chk($sformatf("v%0d dz", i), int'(div_by_zero),
                exp_dz(vecs[i].b));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pulse", i), int'(done), 0);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("v%0d holdq", i), int'(quotient), int'(vecs[i].eq));
            chk($sformatf("v%0d holdr", i), int'(remainder), int'(vecs[i].er));
        end

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd10;
        divisor  = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat++;
        chk("ign busy", int'(busy), 1);
        chk("ign stableq", int'(quotient), 15);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) seen = 1'b1;
        end
        chk("ign seen", int'(seen), 1);
        chk("ign lat", lat, N + 1);
        chk("ign quo", int'(quotient), 16);
        chk("ign rem", int'(remainder), 2);

        // Back-to-back start accepted in the DONE cycle.
        run_op(8'd20, 8'd3, lat, bcnt);
        chk("b2b1 quo", int'(quotient), 6);
        chk("b2b1 rem", int'(remainder), 2);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd4;
        wait_done(lat, bcnt);
        chk("b2b2 lat", lat, N + 1);
        chk("b2b2 quo", int'(quotient), 2);
        chk("b2b2 rem", int'(remainder), 1);

        // Reset at CALC step 4 aborts with no done.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort quo", int'(quotient), 0);
        chk("abort rem", int'(remainder), 0);
        chk("abort dz", int'(div_by_zero), 0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        chk("abort quiet", int'(seen), 0);
        run_op(8'd81, 8'd9, lat, bcnt);
        chk("fresh lat", lat, N + 1);
        chk("fresh quo", int'(quotient), 9);
        chk("fresh rem", int'(remainder), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
